// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types, GF(2^8) helpers and column access functions
package aes_pkg;

  localparam int AES_NB = 4;

  typedef logic [127:0] state_t;
  typedef logic [31:0]  col_t;

  typedef enum logic [1:0] {
    MC_IDLE = 2'd0,
    MC_BUSY = 2'd1,
    MC_DONE = 2'd2
  } mc_fsm_e;

  // Multiply by x modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul2(input logic [7:0] b);
    return xtime(b);
  endfunction

  function automatic logic [7:0] gf_mul3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gf_mul9(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] gf_mul11(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gf_mul13(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] gf_mul14(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

  // Column 0 occupies the most significant 32 bits of the state
  function automatic col_t get_col(input state_t s, input logic [1:0] c);
    return s[127 - 32*int'(c) -: 32];
  endfunction

  function automatic state_t put_col(input state_t s, input logic [1:0] c, input col_t v);
    state_t r;
    r = s;
    r[127 - 32*int'(c) -: 32] = v;
    return r;
  endfunction

endpackage

// File: rtl/mix_single_column.sv
// rtl/mix_single_column.sv - combinational forward/inverse MixColumns for one column
module mix_single_column
  import aes_pkg::*;
(
  input  logic [31:0] col_in,
  input  logic        inv,
  output logic [31:0] col_out
);

  logic [7:0] a0, a1, a2, a3;

  assign a0 = col_in[31:24];
  assign a1 = col_in[23:16];
  assign a2 = col_in[15:8];
  assign a3 = col_in[7:0];

  // Circulant matrix multiply; row r uses the row-0 coefficients rotated right by r
  always_comb begin
    if (inv) begin
      col_out[31:24] = gf_mul14(a0) ^ gf_mul11(a1) ^ gf_mul13(a2) ^ gf_mul9(a3);
      col_out[23:16] = gf_mul9(a0)  ^ gf_mul14(a1) ^ gf_mul11(a2) ^ gf_mul13(a3);
      col_out[15:8]  = gf_mul13(a0) ^ gf_mul9(a1)  ^ gf_mul14(a2) ^ gf_mul11(a3);
      col_out[7:0]   = gf_mul11(a0) ^ gf_mul13(a1) ^ gf_mul9(a2)  ^ gf_mul14(a3);
    end else begin
      col_out[31:24] = gf_mul2(a0) ^ gf_mul3(a1) ^ a2          ^ a3;
      col_out[23:16] = a0          ^ gf_mul2(a1) ^ gf_mul3(a2) ^ a3;
      col_out[15:8]  = a0          ^ a1          ^ gf_mul2(a2) ^ gf_mul3(a3);
      col_out[7:0]   = gf_mul3(a0) ^ a1          ^ a2          ^ gf_mul2(a3);
    end
  end

endmodule

// File: rtl/mix_columns_iter.sv
// rtl/mix_columns_iter.sv - iterative MixColumns, COLS_PER_CYCLE columns per clock
module mix_columns_iter
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  input  logic         inv_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  // Counter step wraps to 0 when all four columns go in one cycle
  localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST = 2'(AES_NB - COLS_PER_CYCLE);

  mc_fsm_e    fsm_q, fsm_d;
  state_t     work_q, work_d;
  logic [1:0] cnt_q, cnt_d;
  logic       inv_q, inv_d;
  logic       out_valid_q, out_valid_d;
  logic       accept;

  col_t col_in  [COLS_PER_CYCLE];
  col_t col_out [COLS_PER_CYCLE];

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    assign col_in[g] = get_col(work_q, cnt_q + 2'(g));

    mix_single_column u_col (
      .col_in  (col_in[g]),
      .inv     (inv_q),
      .col_out (col_out[g])
    );
  end

  assign in_ready  = (fsm_q == MC_IDLE) || ((fsm_q == MC_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign state_out = work_q;

  // Next-state logic: capture, per-cycle column rewrite, and result hand-off
  always_comb begin
    fsm_d       = fsm_q;
    work_d      = work_q;
    cnt_d       = cnt_q;
    inv_d       = inv_q;
    out_valid_d = out_valid_q;
    case (fsm_q)
      MC_BUSY: begin
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
          work_d = put_col(work_d, cnt_q + 2'(g), col_out[g]);
        end
        cnt_d = cnt_q + STEP;
        if (cnt_q == LAST) begin
          fsm_d       = MC_DONE;
          out_valid_d = 1'b1;
        end
      end
      MC_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          fsm_d       = MC_IDLE;
        end
      end
      default: ;
    endcase
    // A new block can start from IDLE or directly out of DONE
    if (accept) begin
      fsm_d  = MC_BUSY;
      work_d = state_in;
      inv_d  = inv_in;
      cnt_d  = 2'd0;
    end
  end

  // State, working register and registered output flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= MC_IDLE;
      work_q      <= '0;
      cnt_q       <= 2'd0;
      inv_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      work_q      <= work_d;
      cnt_q       <= cnt_d;
      inv_q       <= inv_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_mix_columns_iter.sv
// tb/tb_mix_columns_iter.sv - scoreboard bench for mix_columns_iter at 1, 2 and 4 columns per cycle
module tb_mix_columns_iter;

  typedef struct packed {
    logic [127:0] x;
    logic         inv;
  } item_t;

  localparam logic [127:0] FIPS_IN  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
  localparam logic [127:0] FIPS_OUT = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
  localparam logic [127:0] KC_IN    = 128'hdb135345_f20a225c_01010101_2d26314c;
  localparam logic [127:0] KC_OUT   = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
  localparam int           N_RAND   = 1000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic         inv_in    [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [127:0] state_in  [3];
  logic [127:0] state_out [3];

  int n_checks = 0;
  int n_errors = 0;

  item_t q0[$];
  item_t q1[$];
  item_t q2[$];

  always #5 clk = ~clk;

  mix_columns_iter #(.COLS_PER_CYCLE(1)) u_c1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .state_in(state_in[0]), .inv_in(inv_in[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .state_out(state_out[0]));

  mix_columns_iter #(.COLS_PER_CYCLE(2)) u_c2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .state_in(state_in[1]), .inv_in(inv_in[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .state_out(state_out[1]));

  mix_columns_iter #(.COLS_PER_CYCLE(4)) u_c4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .state_in(state_in[2]), .inv_in(inv_in[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .state_out(state_out[2]));

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference multiply by shift-and-add, independent of the xtime chains
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [127:0] mix_model(input logic [127:0] s, input logic inv);
    logic [7:0]   coef [4];
    logic [7:0]   acc;
    logic [127:0] r = '0;
    if (inv) begin
      coef[0] = 8'd14; coef[1] = 8'd11; coef[2] = 8'd13; coef[3] = 8'd9;
    end else begin
      coef[0] = 8'd2;  coef[1] = 8'd3;  coef[2] = 8'd1;  coef[3] = 8'd1;
    end
    for (int c = 0; c < 4; c++) begin
      for (int rr = 0; rr < 4; rr++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) begin
          acc = acc ^ gmul(coef[(j - rr + 4) % 4], s[127 - (c*32 + j*8) -: 8]);
        end
        r[127 - (c*32 + rr*8) -: 8] = acc;
      end
    end
    return r;
  endfunction

  task automatic sb_push(input int k, input item_t it);
    case (k)
      0:       q0.push_back(it);
      1:       q1.push_back(it);
      default: q2.push_back(it);
    endcase
  endtask

  task automatic sb_pop(input int k, output item_t it, output logic ok);
    ok = 1'b1;
    it = '0;
    case (k)
      0:       if (q0.size() > 0) it = q0.pop_front(); else ok = 1'b0;
      1:       if (q1.size() > 0) it = q1.pop_front(); else ok = 1'b0;
      default: if (q2.size() > 0) it = q2.pop_front(); else ok = 1'b0;
    endcase
  endtask

  // Present a state and wait for the accepting edge; returns at the following negedge
  task automatic accept(input int k, input logic [127:0] x, input logic inv);
    int n = 0;
    @(negedge clk);
    state_in[k] = x;
    inv_in[k]   = inv;
    in_valid[k] = 1'b1;
    out_ready[k] = 1'b0;
    #1;
    while (!in_ready[k] && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("accept_timeout", {127'd0, in_ready[k]}, 128'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid[k] = 1'b0;
  endtask

  task automatic wait_out(input int k, output int lat);
    lat = 0;
    while (!out_valid[k] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic drain(input int k, input string tag);
    out_ready[k] = 1'b1;
    @(negedge clk);
    out_ready[k] = 1'b0;
    check({tag, "_drain"}, {127'd0, out_valid[k]}, 128'd0);
  endtask

  task automatic run_one(input int k, input logic [127:0] x, input logic inv,
                         input logic [127:0] exp, input int exp_lat, input string tag);
    int lat;
    accept(k, x, inv);
    wait_out(k, lat);
    check({tag, "_lat"}, 128'(lat), 128'(exp_lat));
    check({tag, "_out"}, state_out[k], exp);
    drain(k, tag);
  endtask

  initial begin
    int    lat;
    logic  seen;
    logic  done;
    logic  ok;
    logic  have [3];
    item_t cur  [3];
    item_t it;
    int    sent [3];
    logic [127:0] held;

    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid[k] = 1'b0; inv_in[k] = 1'b0; out_ready[k] = 1'b0; state_in[k] = '0;
      have[k] = 1'b0; sent[k] = 0; cur[k] = '0;
    end
    #23;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_out_valid%0d", k), {127'd0, out_valid[k]}, 128'd0);
      check($sformatf("rst_in_ready%0d", k),  {127'd0, in_ready[k]},  128'd1);
      check($sformatf("rst_state_out%0d", k), state_out[k], 128'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    run_one(0, FIPS_IN, 1'b0, FIPS_OUT, 4, "fips_c1");
    run_one(1, KC_IN,   1'b0, KC_OUT,   2, "kc_c2");
    run_one(2, KC_OUT,  1'b1, KC_IN,    1, "inv_c4");
    run_one(2, FIPS_IN, 1'b0, FIPS_OUT, 1, "fips_c4");
    run_one(1, KC_OUT,  1'b1, KC_IN,    2, "inv_c2");

    // Backpressure with ignored input pulses, then same-cycle re-accept out of DONE
    accept(0, KC_IN, 1'b0);
    wait_out(0, lat);
    check("bp_lat", 128'(lat), 128'd4);
    held = state_out[0];
    check("bp_out", held, KC_OUT);
    for (int i = 0; i < 5; i++) begin
      in_valid[0] = 1'b1;
      state_in[0] = {$urandom, $urandom, $urandom, $urandom};
      inv_in[0]   = 1'($urandom);
      #1;
      check("bp_in_ready", {127'd0, in_ready[0]}, 128'd0);
      @(negedge clk);
      check("bp_hold", state_out[0], KC_OUT);
      check("bp_valid", {127'd0, out_valid[0]}, 128'd1);
    end
    state_in[0]  = FIPS_IN;
    inv_in[0]    = 1'b0;
    out_ready[0] = 1'b1;
    #1;
    check("bp_reaccept_ready", {127'd0, in_ready[0]}, 128'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b0;
    wait_out(0, lat);
    check("bp2_lat", 128'(lat), 128'd4);
    check("bp2_out", state_out[0], FIPS_OUT);
    drain(0, "bp2");

    // Reset two cycles into BUSY
    accept(0, FIPS_IN, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {127'd0, out_valid[0]}, 128'd0);
    check("mid_rst_ready", {127'd0, in_ready[0]},  128'd1);
    check("mid_rst_state", state_out[0], 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid[0]) seen = 1'b1;
    end
    check("mid_rst_no_valid", {127'd0, seen}, 128'd0);
    run_one(0, FIPS_IN, 1'b0, FIPS_OUT, 4, "post_rst");

    // Random throttled regression on all three instances in parallel
    done = 1'b0;
    for (int cyc = 0; cyc < 60000 && !done; cyc++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        out_ready[k] = ($urandom_range(0, 3) != 0);
        if (!have[k] && sent[k] < N_RAND) begin
          cur[k]  = {$urandom, $urandom, $urandom, $urandom, 1'($urandom)};
          have[k] = 1'b1;
        end
        if (have[k] && $urandom_range(0, 3) != 0) begin
          in_valid[k] = 1'b1;
          state_in[k] = cur[k].x;
          inv_in[k]   = cur[k].inv;
        end else begin
          in_valid[k] = 1'b0;
          state_in[k] = {$urandom, $urandom, $urandom, $urandom};
          inv_in[k]   = 1'($urandom);
        end
      end
      #1;
      for (int k = 0; k < 3; k++) begin
        if (in_valid[k] && in_ready[k]) begin
          sb_push(k, cur[k]);
          have[k] = 1'b0;
          sent[k]++;
        end
        if (out_valid[k] && out_ready[k]) begin
          sb_pop(k, it, ok);
          if (!ok) begin
            check($sformatf("sb_underflow%0d", k), 128'd1, 128'd0);
          end else begin
            check($sformatf("rand_out%0d", k), state_out[k], mix_model(it.x, it.inv));
            if (!it.inv) check($sformatf("roundtrip%0d", k), mix_model(state_out[k], 1'b1), it.x);
          end
        end
      end
      done = (sent[0] == N_RAND) && (sent[1] == N_RAND) && (sent[2] == N_RAND) &&
             (q0.size() == 0) && (q1.size() == 0) && (q2.size() == 0);
    end
    check("rand_complete", {127'd0, done}, 128'd1);
    for (int k = 0; k < 3; k++) begin
      in_valid[k]  = 1'b0;
      out_ready[k] = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
